// File: rtl/obi_req_blocker.sv
// obi_req_blocker: holds one core OBI access while req_blocker_ctrl swaps the
// addressed 512 B block into SRAM, then forwards it to the returned slot.
// Only one transaction is in flight at a time.

package obi_req_blocker_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } mgr_obi_rsp_t;

endpackage

module obi_req_blocker
  import obi_req_blocker_pkg::*;
#(
  parameter type         obi_req_t    = mgr_obi_req_t,
  parameter type         obi_rsp_t    = mgr_obi_rsp_t,
  parameter int unsigned BlockOffsetW = 9,
  parameter int unsigned BlockAddrW   = 21,
  parameter int unsigned NumSlots     = 8,
  parameter logic [31:0] SramBase     = 32'h1000_0000,
  localparam int unsigned IdxW        = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bypass_i,
  input  obi_req_t              sbr_obi_req_i,
  output obi_rsp_t              sbr_obi_rsp_o,
  output obi_req_t              mgr_obi_req_o,
  input  obi_rsp_t              mgr_obi_rsp_i,
  output logic [BlockAddrW-1:0] req_addr_o,
  output logic                  valid_o,
  input  logic [IdxW-1:0]       sram_addr_idx_i,
  input  logic                  block_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    ISSUE    = 2'd2,
    WAIT_RSP = 2'd3
  } state_e;

  state_e          state_q;
  logic [31:0]     addr_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic [3:0]      aid_q;
  logic            bypass_q;
  logic [IdxW-1:0] idx_q;

  logic [31:0]     remapAddr;
  logic [3:0]      unusedSramRid;

  // The SRAM's own rid is replaced by the latched core aid, so it is not needed.
  assign unusedSramRid = mgr_obi_rsp_i.r.rid;

  // Slot-relative SRAM address: slot index above the in-block byte offset, wrapping mod 2^32.
  assign remapAddr = SramBase + 32'({idx_q, addr_q[BlockOffsetW-1:0]});

  // Transaction FSM: latch the core access, wait for the controller, issue, then await the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      aid_q    <= '0;
      bypass_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sbr_obi_req_i.req) begin
            addr_q   <= sbr_obi_req_i.a.addr;
            we_q     <= sbr_obi_req_i.a.we;
            be_q     <= sbr_obi_req_i.a.be;
            wdata_q  <= sbr_obi_req_i.a.wdata;
            aid_q    <= sbr_obi_req_i.a.aid;
            bypass_q <= bypass_i;
            state_q  <= bypass_i ? ISSUE : LOOKUP;
          end
        end
        LOOKUP: begin
          if (!block_i) begin
            idx_q   <= sram_addr_idx_i;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (mgr_obi_rsp_i.gnt) begin
            state_q <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mgr_obi_rsp_i.rvalid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state; the core grant is gated by reset so nothing is accepted while held.
  always_comb begin
    sbr_obi_rsp_o = '0;
    mgr_obi_req_o = '0;
    valid_o       = 1'b0;
    req_addr_o    = '0;
    unique case (state_q)
      IDLE: begin
        sbr_obi_rsp_o.gnt = sbr_obi_req_i.req & ~rst_i;
      end
      LOOKUP: begin
        valid_o    = 1'b1;
        req_addr_o = addr_q[BlockOffsetW +: BlockAddrW];
      end
      ISSUE: begin
        mgr_obi_req_o.req     = 1'b1;
        mgr_obi_req_o.a.addr  = bypass_q ? addr_q : remapAddr;
        mgr_obi_req_o.a.we    = we_q;
        mgr_obi_req_o.a.be    = be_q;
        mgr_obi_req_o.a.wdata = wdata_q;
        mgr_obi_req_o.a.aid   = aid_q;
      end
      WAIT_RSP: begin
        if (mgr_obi_rsp_i.rvalid) begin
          sbr_obi_rsp_o.rvalid  = 1'b1;
          sbr_obi_rsp_o.r.rdata = mgr_obi_rsp_i.r.rdata;
          sbr_obi_rsp_o.r.err   = mgr_obi_rsp_i.r.err;
          sbr_obi_rsp_o.r.rid   = aid_q;
        end
      end
      default: ;
    endcase
  end

endmodule
